conv_window_buffer: RTL
=======================

Name: conv_window_buffer

Overview:
Upstream feeder for the convolution engine. Accepts a row-major stream of 16-bit fixed-point feature-map pixels from the DMA side and emits every valid 5x5 window (stride 1, no padding) in raster order. Holds K-1 rows in internal line buffers so each pixel is read from memory only once. One frame per start; feature-map width is configurable per frame.

Parameters:
DATA_W, 16, pixel width in bits (signed, same Q-format as the conv engine)
MAX_WIDTH, 32, largest supported square feature-map side
K, 5, window side

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_width  in  6  feature-map side W; sampled on accepted frame_start; legal range K..MAX_WIDTH
frame_start  in  1  single-cycle start pulse; honoured only in IDLE
cfg_error  out  1  pulses 1 cycle when frame_start carries an illegal cfg_width
in_valid  in  1  input pixel valid
in_ready  out  1  buffer can accept a pixel this cycle
in_data  in  DATA_W  pixel; raster order, row 0 col 0 first
win_valid  out  1  window register holds a valid window
win_ready  in  1  conv engine consumes the window
win_data  out  K*K*DATA_W  window; element [r][c] at bits (r*K+c)*DATA_W +: DATA_W; r=0 is topmost row, c=0 leftmost column
win_row  out  6  top-left row of current window, 0..W-K
win_col  out  6  top-left column of current window, 0..W-K
frame_done  out  1  1-cycle pulse after last window handshake

Behaviour:
- Reset (synchronous, any state, including mid-frame): state IDLE; in_ready, win_valid, frame_done, cfg_error = 0; win_data, win_row, win_col = 0; pixel counters cleared; line-buffer contents don't-care.
- States: IDLE -> LOAD on frame_start with legal cfg_width; LOAD -> DRAIN when pixel (W-1,W-1) is accepted; DRAIN -> IDLE when the final window handshakes (win_valid && win_ready), frame_done pulses the next cycle.
- frame_start with cfg_width < K or > MAX_WIDTH: cfg_error pulses the next cycle, stays IDLE. frame_start outside IDLE: ignored, no error.
- in_ready = 1 only in LOAD and only when (!win_valid || win_ready). Input handshake = in_valid && in_ready.
- Each accepted pixel at (row i, col j) is shifted into the window shift registers and line buffers. If i >= K-1 and j >= K-1, the window with top-left (i-K+1, j-K+1) is loaded into the output register on the same edge: win_valid = 1 the next cycle, win_row/win_col set. Latency is 1 cycle from the completing pixel's handshake to win_valid.
- Output register is a single stage; win_data, win_row and win_col are held stable while win_valid && !win_ready. A window consumed and a new one loaded in the same cycle keeps win_valid high with no bubble.
- Column counter wraps at W-1 and increments the row counter. No pixels are accepted after (W-1,W-1). Windows per frame = (W-K+1)^2. Pixel data passes through unmodified (no arithmetic).
- Simultaneous frame_done and a new frame_start: frame_start is honoured only once the state is IDLE, i.e. the cycle of the frame_done pulse or later.

Optional Feature:
CONV_WIN_STALL_CNT_EN. When defined, adds output stall_cycles (16 bits). It counts cycles with win_valid && !win_ready, saturates at 0xFFFF, is cleared on an accepted frame_start and by rst, and holds its value after frame_done. When not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- W=5, pixels 0..24, win_ready=1 -> exactly one window with [0][0]=0, [4][4]=24, row/col=(0,0); frame_done 1 cycle after its handshake.
- W=32, pixel = r*32+c, win_ready=1 -> 784 windows; first [4][4]=132; last win_row=win_col=27 with [0][0]=891 and [4][4]=1023; in_ready never drops.
- W=32, win_ready toggled by a random 50% pattern -> same 784 windows in the same order; win_data stable while stalled; no pixel lost or duplicated.
- frame_start with cfg_width=4, then 33 -> cfg_error pulse each time, state stays IDLE, in_ready=0.
- rst asserted after 100 pixels of a W=14 frame -> next cycle all outputs 0; new W=10 frame then yields 36 correct windows.
- frame_start during LOAD -> ignored, frame completes normally. With CONV_WIN_STALL_CNT_EN and win_ready held 0 for 7 cycles -> stall_cycles=7.

Source files
------------

// File: rtl/conv_window_buffer.sv
// rtl/conv_window_buffer.sv - streams every valid KxK window (stride 1) of a row-major feature map
// Optional stall counter output enabled by defining CONV_WIN_STALL_CNT_EN.
module conv_window_buffer #(
   parameter int DATA_W    = 16,
   parameter int MAX_WIDTH = 32,
   parameter int K         = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            cfg_width,
   input  logic                  frame_start,
   output logic                  cfg_error,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [K*K*DATA_W-1:0] win_data,
   output logic [5:0]            win_row,
   output logic [5:0]            win_col,
`ifdef CONV_WIN_STALL_CNT_EN
   output logic [15:0]           stall_cycles,
`endif
   output logic                  frame_done
);

   localparam int         AW  = $clog2(MAX_WIDTH);
   localparam logic [5:0] KM1 = 6'(K - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

   state_t                r_state;
   logic [5:0]            r_width;
   logic [5:0]            r_row;
   logic [5:0]            r_col;
   // r_lb[m][j] holds pixel (i-K+1+m, j) while pixel (i, j) is being accepted
   logic [DATA_W-1:0]     r_lb [K-1][MAX_WIDTH];
   logic [DATA_W-1:0]     r_sr [K][K];
   logic                  r_win_valid;
   logic [K*K*DATA_W-1:0] r_win_data;
   logic [5:0]            r_win_row;
   logic [5:0]            r_win_col;
   logic                  r_frame_done;
   logic                  r_cfg_error;

   logic                  w_cfg_bad;
   logic                  w_start_ok;
   logic                  w_in_ready;
   logic                  w_in_fire;
   logic                  w_win_fire;
   logic                  w_last_pix;
   logic                  w_row_end;
   logic                  w_win_done;
   logic [AW-1:0]         w_addr;
   logic [DATA_W-1:0]     w_col [K];
   logic [K*K*DATA_W-1:0] w_win_next;

   assign w_cfg_bad  = (cfg_width < 6'(K)) || ({1'b0, cfg_width} > 7'(MAX_WIDTH));
   assign w_start_ok = (r_state == S_IDLE) && frame_start && !w_cfg_bad;
   assign w_in_ready = (r_state == S_LOAD) && (!r_win_valid || win_ready);
   assign w_in_fire  = in_valid && w_in_ready;
   assign w_win_fire = r_win_valid && win_ready;
   assign w_row_end  = (r_col == r_width - 6'd1);
   assign w_last_pix = (r_row == r_width - 6'd1) && w_row_end;
   assign w_win_done = (r_row >= KM1) && (r_col >= KM1);
   assign w_addr     = r_col[AW-1:0];

   // Column entering the window: K-1 buffered rows above plus the incoming pixel
   always_comb begin
      for (int r = 0; r < K - 1; r++) begin
         w_col[r] = r_lb[r][w_addr];
      end
      w_col[K-1] = in_data;
      w_win_next = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            w_win_next[(r*K+c)*DATA_W +: DATA_W] = r_sr[r][c+1];
         end
         w_win_next[(r*K+K-1)*DATA_W +: DATA_W] = w_col[r];
      end
   end

   // Storage carries no reset: every location is rewritten before a window reads it
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         for (int r = 0; r < K - 1; r++) begin
            r_lb[r][w_addr] <= w_col[r+1];
         end
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               r_sr[r][c] <= r_sr[r][c+1];
            end
            r_sr[r][K-1] <= w_col[r];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_width      <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_win_valid  <= 1'b0;
         r_win_data   <= '0;
         r_win_row    <= '0;
         r_win_col    <= '0;
         r_frame_done <= 1'b0;
         r_cfg_error  <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_cfg_error  <= (r_state == S_IDLE) && frame_start && w_cfg_bad;

         if (w_in_fire && w_win_done) begin
            r_win_valid <= 1'b1;
            r_win_data  <= w_win_next;
            r_win_row   <= r_row - KM1;
            r_win_col   <= r_col - KM1;
         end else if (w_win_fire) begin
            r_win_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_width <= cfg_width;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_in_fire) begin
                  if (w_last_pix) begin
                     r_state <= S_DRAIN;
                  end else if (w_row_end) begin
                     r_col <= '0;
                     r_row <= r_row + 6'd1;
                  end else begin
                     r_col <= r_col + 6'd1;
                  end
               end
            end
            S_DRAIN: begin
               // Only the final window can be pending once the last pixel is in
               if (w_win_fire) begin
                  r_state      <= S_IDLE;
                  r_frame_done <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef CONV_WIN_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst || w_start_ok) begin
         r_stall_cnt <= '0;
      end else if (r_win_valid && !win_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cycles = r_stall_cnt;
`endif

   assign in_ready   = w_in_ready;
   assign win_valid  = r_win_valid;
   assign win_data   = r_win_data;
   assign win_row    = r_win_row;
   assign win_col    = r_win_col;
   assign frame_done = r_frame_done;
   assign cfg_error  = r_cfg_error;

endmodule
